// File: rtl/cnm_arb_pkg.sv
// Shared definitions for the complex-multiplier arbiter: FSM state encodings,
// the requester-ID width helper and the default watchdog limit.
package cnm_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_ERR   = 3'd4
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 32'sd64;

    // Ceiling log2, never below 1 so a requester index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            result = ((32'sd1 << i) < value) ? (i + 32'sd1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: grants the first asserted request found
// scanning upward from (last_grant + 1) mod N_REQ with wrap-around.
module rr_priority_picker
    import cnm_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    int   idx_s;
    logic hit_s;

    // Priority scan; the first hit latches any_req so later candidates are masked.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx_s     = 32'sd0;
        hit_s     = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx_s        = (int'(last_grant) + off) % N_REQ;
            hit_s        = req[idx_s] & ~any_req;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? ID_W'(idx_s) : grant_idx;
            any_req      = any_req | hit_s;
        end
    end

endmodule

// File: rtl/complex_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier among N_REQ requesters,
// one transaction in flight. Optional watchdog enabled by CNM_ARB_TIMEOUT_EN.
module complex_mult_arbiter
    import cnm_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_val,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_op_1_re,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_op_1_im,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_op_2_re,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_op_2_im,
    output logic [N_REQ-1:0]            rsp_val,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [2*DATA_WIDTH-1:0]     rsp_re,
    output logic [2*DATA_WIDTH-1:0]     rsp_im,
    output logic                        rsp_err,
    output logic                        mult_op_val,
    input  logic                        mult_op_ready,
    output logic [DATA_WIDTH-1:0]       mult_op_1_re,
    output logic [DATA_WIDTH-1:0]       mult_op_1_im,
    output logic [DATA_WIDTH-1:0]       mult_op_2_re,
    output logic [DATA_WIDTH-1:0]       mult_op_2_im,
    input  logic                        mult_res_val,
    output logic                        mult_res_ready,
    input  logic [2*DATA_WIDTH-1:0]     mult_result_re,
    input  logic [2*DATA_WIDTH-1:0]     mult_result_im,
    output logic                        mult_sw_rst
);

    localparam int ID_W = clog2(N_REQ);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [ID_W-1:0]       last_grant_r;
    logic [ID_W-1:0]       owner_r;
    logic [ID_W-1:0]       grant_idx_s;
    logic [N_REQ-1:0]      grant_s;
    logic                  any_req_s;
    logic                  req_hs_s;
    logic                  timeout_hit_s;
    logic [DATA_WIDTH-1:0] op_1_re_r;
    logic [DATA_WIDTH-1:0] op_1_im_r;
    logic [DATA_WIDTH-1:0] op_2_re_r;
    logic [DATA_WIDTH-1:0] op_2_im_r;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req        (req_val),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any_req    (any_req_s)
    );

    // The picker only grants a requester whose req_val is high, so any grant in IDLE is a handshake.
    assign req_hs_s = (state_r == ST_IDLE) && any_req_s;

    assign mult_op_1_re = op_1_re_r;
    assign mult_op_1_im = op_1_im_r;
    assign mult_op_2_re = op_2_re_r;
    assign mult_op_2_im = op_2_im_r;

`ifdef CNM_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 32'sd1);

    logic [CNT_W-1:0] wdog_cnt_r;

    // Trips on the WAIT cycle that would bring the idle count up to TIMEOUT_CYCLES.
    assign timeout_hit_s = (wdog_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'sd1));

    // Watchdog: cleared on entry to WAIT, counts WAIT cycles without a multiplier result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_r <= '0;
        end else if ((state_r == ST_SEND) && mult_op_ready) begin
            wdog_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !mult_res_val) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
        end else begin
            wdog_cnt_r <= wdog_cnt_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;

    // Without the watchdog TIMEOUT_CYCLES has no effect; it is kept for a uniform parameter list.
    if (TIMEOUT_CYCLES < 32'sd1) begin : g_timeout_param_unused
    end
`endif

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (mult_op_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (mult_res_val && rsp_ready[owner_r]) begin
                    state_nxt_s = ST_IDLE;
                end else if (!mult_res_val && timeout_hit_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
`ifdef CNM_ARB_TIMEOUT_EN
            ST_ABORT: begin
                state_nxt_s = ST_ERR;
            end
            ST_ERR: begin
                if (rsp_ready[owner_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs; the WAIT result path is combinational so no latency is added.
    always_comb begin
        req_ready      = '0;
        rsp_val        = '0;
        rsp_re         = '0;
        rsp_im         = '0;
        rsp_err        = 1'b0;
        mult_op_val    = 1'b0;
        mult_res_ready = 1'b0;
        mult_sw_rst    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready = grant_s;
            end
            ST_SEND: begin
                mult_op_val = 1'b1;
            end
            ST_WAIT: begin
                rsp_val[owner_r] = mult_res_val;
                mult_res_ready   = rsp_ready[owner_r];
                rsp_re           = mult_result_re;
                rsp_im           = mult_result_im;
            end
`ifdef CNM_ARB_TIMEOUT_EN
            ST_ABORT: begin
                mult_sw_rst = 1'b1;
            end
            ST_ERR: begin
                rsp_val[owner_r] = 1'b1;
                rsp_err          = 1'b1;
            end
`endif
            default: begin
                req_ready = '0;
            end
        endcase
    end

    // State, grant history and operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= ID_W'(N_REQ - 32'sd1);
            owner_r      <= '0;
            op_1_re_r    <= '0;
            op_1_im_r    <= '0;
            op_2_re_r    <= '0;
            op_2_im_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (req_hs_s) begin
                owner_r      <= grant_idx_s;
                last_grant_r <= grant_idx_s;
                op_1_re_r    <= req_op_1_re[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                op_1_im_r    <= req_op_1_im[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                op_2_re_r    <= req_op_2_re[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                op_2_im_r    <= req_op_2_im[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                owner_r      <= owner_r;
                last_grant_r <= last_grant_r;
                op_1_re_r    <= op_1_re_r;
                op_1_im_r    <= op_1_im_r;
                op_2_re_r    <= op_2_re_r;
                op_2_im_r    <= op_2_im_r;
            end
        end
    end

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Directed bench for complex_mult_arbiter; the bench plays the multiplier and all requesters.
// The timeout sequence is selected by CNM_ARB_TIMEOUT_EN, matching the RTL build.
module tb_complex_mult_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_val;
    logic [3:0]  req_ready;
    logic [31:0] req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im;
    logic [3:0]  rsp_val;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_re, rsp_im;
    logic        rsp_err;
    logic        mult_op_val;
    logic        mult_op_ready;
    logic [7:0]  mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im;
    logic        mult_res_val;
    logic        mult_res_ready;
    logic [15:0] mult_result_re, mult_result_im;
    logic        mult_sw_rst;

    int checks   = 0;
    int failures = 0;

    complex_mult_arbiter #(
        .DATA_WIDTH     (8),
        .N_REQ          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_val        (req_val),
        .req_ready      (req_ready),
        .req_op_1_re    (req_op_1_re),
        .req_op_1_im    (req_op_1_im),
        .req_op_2_re    (req_op_2_re),
        .req_op_2_im    (req_op_2_im),
        .rsp_val        (rsp_val),
        .rsp_ready      (rsp_ready),
        .rsp_re         (rsp_re),
        .rsp_im         (rsp_im),
        .rsp_err        (rsp_err),
        .mult_op_val    (mult_op_val),
        .mult_op_ready  (mult_op_ready),
        .mult_op_1_re   (mult_op_1_re),
        .mult_op_1_im   (mult_op_1_im),
        .mult_op_2_re   (mult_op_2_re),
        .mult_op_2_im   (mult_op_2_im),
        .mult_res_val   (mult_res_val),
        .mult_res_ready (mult_res_ready),
        .mult_result_re (mult_result_re),
        .mult_result_im (mult_result_im),
        .mult_sw_rst    (mult_sw_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         req;
        logic [7:0] a, b, c, d;
        logic [15:0] exp_re, exp_im;
        int         op_stall, res_delay, rsp_stall;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] rot_a[4], rot_b[4], rot_c[4], rot_d[4];
    logic [15:0] rot_re[4], rot_im[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Multiplier model: (a+bj)(c+dj) at full 16-bit width.
    function automatic logic [31:0] cmul(input logic [7:0] a, b, c, d);
        logic signed [15:0] sa, sb, sc, sd, re, im;
        sa = 16'($signed(a));
        sb = 16'($signed(b));
        sc = 16'($signed(c));
        sd = 16'($signed(d));
        re = sa * sc - sb * sd;
        im = sa * sd + sb * sc;
        return {im, re};
    endfunction

    task automatic set_ops(input int r, input logic [7:0] a, b, c, d);
        req_op_1_re[r*8 +: 8] = a;
        req_op_1_im[r*8 +: 8] = b;
        req_op_2_re[r*8 +: 8] = c;
        req_op_2_im[r*8 +: 8] = d;
    endtask

    task automatic drive_result();
        {mult_result_im, mult_result_re} = cmul(mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_val"}, rsp_val, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_op_val"}, mult_op_val, 0);
        chk({tag, "_res_ready"}, mult_res_ready, 0);
        chk({tag, "_sw_rst"}, mult_sw_rst, 0);
        chk({tag, "_rsp_re"}, rsp_re, 0);
        chk({tag, "_rsp_im"}, rsp_im, 0);
        chk({tag, "_ops"}, {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im}, 0);
    endtask

    // One single-requester transaction with optional stalls on each channel.
    task automatic run_vec(input vec_t v);
        logic [3:0] own;
        own = 4'b0001 << v.req;
        @(negedge clk);
        req_val = own;
        set_ops(v.req, v.a, v.b, v.c, v.d);
        rsp_ready = 4'h0;
        #1;
        chk("grant_same_cycle", req_ready, own);
        chk("op_val_in_idle", mult_op_val, 0);
        for (int s = 0; s <= v.op_stall; s++) begin
            @(negedge clk);
            req_val = ~own;
            mult_op_ready = (s == v.op_stall);
            #1;
            chk("op_val_send", mult_op_val, 1);
            chk("op_operands", {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im},
                {v.a, v.b, v.c, v.d});
            chk("no_grant_send", req_ready, 0);
        end
        for (int w = 0; w <= v.res_delay + v.rsp_stall; w++) begin
            @(negedge clk);
            mult_op_ready = 1'b0;
            mult_res_val = (w >= v.res_delay);
            rsp_ready = (w >= v.res_delay + v.rsp_stall) ? 4'hF : ~own;
            drive_result();
            #1;
            chk("rsp_val_owner", rsp_val, mult_res_val ? own : 4'h0);
            chk("res_ready_owner", mult_res_ready, (w >= v.res_delay + v.rsp_stall) ? 1 : 0);
            chk("no_grant_wait", req_ready, 0);
            chk("op_val_wait", mult_op_val, 0);
            chk("rsp_err_wait", rsp_err, 0);
            if (mult_res_val) begin
                chk("rsp_re", rsp_re, v.exp_re);
                chk("rsp_im", rsp_im, v.exp_im);
            end else begin
                chk("sw_rst_wait", mult_sw_rst, 0);
            end
        end
        @(negedge clk);
        mult_res_val = 1'b0;
        req_val = 4'h0;
        rsp_ready = 4'h0;
        #1;
        chk("done_rsp_val", rsp_val, 0);
        chk("done_res_ready", mult_res_ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_val = 4'h0;
        rsp_ready = 4'h0;
        mult_op_ready = 1'b0;
        mult_res_val = 1'b0;
        mult_result_re = 16'h0;
        mult_result_im = 16'h0;
        req_op_1_re = 32'h0;
        req_op_1_im = 32'h0;
        req_op_2_re = 32'h0;
        req_op_2_im = 32'h0;

        vecs[0] = '{2, 8'd3, 8'd4, 8'd1, 8'hFE, 16'd11, 16'hFFFE, 0, 0, 0};
        vecs[1] = '{1, 8'd2, 8'd3, 8'd2, 8'hFF, 16'd7, 16'd4, 3, 2, 0};
        vecs[2] = '{0, 8'h80, 8'd0, 8'h80, 8'd0, 16'h4000, 16'd0, 1, 0, 5};
        vecs[3] = '{3, 8'd127, 8'h80, 8'hFF, 8'd0, 16'hFF81, 16'd128, 0, 4, 1};
        vecs[4] = '{0, 8'hFC, 8'd5, 8'hFD, 8'hFF, 16'd17, 16'hFFF5, 0, 1, 0};

        rot_a = '{8'd1, 8'd2, 8'd3, 8'hFC};
        rot_b = '{8'd2, 8'd3, 8'd4, 8'd5};
        rot_c = '{8'd2, 8'd2, 8'd1, 8'hFD};
        rot_d = '{8'd0, 8'hFF, 8'hFE, 8'hFF};
        rot_re = '{16'd2, 16'd7, 16'd11, 16'd17};
        rot_im = '{16'd4, 16'd4, 16'hFFFE, 16'hFFF5};

        repeat (2) @(negedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Multiplier never answers: watchdog abort, or indefinite wait without it.
        @(negedge clk);
        req_val = 4'b0010;
        set_ops(1, 8'd2, 8'd3, 8'd2, 8'hFF);
        #1;
        chk("tmo_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_val = 4'h0;
        mult_op_ready = 1'b1;
        #1;
        chk("tmo_op_val", mult_op_val, 1);
`ifdef CNM_ARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            mult_op_ready = 1'b0;
            #1;
            chk("tmo_no_sw_rst_yet", mult_sw_rst, 0);
            chk("tmo_no_rsp_yet", rsp_val, 0);
        end
        @(negedge clk);
        #1;
        chk("tmo_sw_rst_pulse", mult_sw_rst, 1);
        chk("tmo_abort_rsp_val", rsp_val, 0);
        chk("tmo_abort_res_ready", mult_res_ready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rsp_ready = 4'b1101;
            #1;
            chk("tmo_sw_rst_single", mult_sw_rst, 0);
            chk("tmo_err_rsp_val", rsp_val, 4'b0010);
            chk("tmo_err_flag", rsp_err, 1);
            chk("tmo_err_data", {rsp_re, rsp_im}, 0);
        end
        @(negedge clk);
        rsp_ready = 4'b0010;
        #1;
        chk("tmo_err_held", rsp_val, 4'b0010);
        chk("tmo_err_flag_held", rsp_err, 1);
        @(negedge clk);
        rsp_ready = 4'h0;
        #1;
        chk("tmo_back_idle_rsp", rsp_val, 0);
        chk("tmo_back_idle_err", rsp_err, 0);
`else
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            mult_op_ready = 1'b0;
            #1;
            chk("wait_no_sw_rst", mult_sw_rst, 0);
            chk("wait_no_rsp", rsp_val, 0);
            chk("wait_no_err", rsp_err, 0);
        end
        @(negedge clk);
        mult_res_val = 1'b1;
        rsp_ready = 4'b0010;
        drive_result();
        #1;
        chk("late_rsp_val", rsp_val, 4'b0010);
        chk("late_rsp_data", {rsp_re, rsp_im}, {16'd7, 16'd4});
        chk("late_rsp_err", rsp_err, 0);
        @(negedge clk);
        mult_res_val = 1'b0;
        rsp_ready = 4'h0;
        #1;
        chk("late_done", rsp_val, 0);
`endif

        // Reset during WAIT: silent abort, priority back to requester 0.
        @(negedge clk);
        req_val = 4'b0010;
        #1;
        chk("rstw_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_val = 4'h0;
        mult_op_ready = 1'b1;
        @(negedge clk);
        mult_op_ready = 1'b0;
        rsp_ready = 4'hF;
        #1;
        chk("rstw_in_wait", mult_res_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mult_res_val = 1'b1;
        #1;
        chk_idle_zero("rstw");

        // All requesters hold req_val: strict rotation, back-to-back.
        for (int r = 0; r < 4; r++) begin
            set_ops(r, rot_a[r], rot_b[r], rot_c[r], rot_d[r]);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mult_res_val = 1'b0;
            req_val = 4'hF;
            rsp_ready = 4'hF;
            #1;
            chk("rot_grant", req_ready, 4'b0001 << (k % 4));
            @(negedge clk);
            mult_op_ready = 1'b1;
            #1;
            chk("rot_op_val", mult_op_val, 1);
            chk("rot_operands", {mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im},
                {rot_a[k % 4], rot_b[k % 4], rot_c[k % 4], rot_d[k % 4]});
            @(negedge clk);
            mult_op_ready = 1'b0;
            mult_res_val = 1'b1;
            drive_result();
            #1;
            chk("rot_rsp_owner", rsp_val, 4'b0001 << (k % 4));
            chk("rot_rsp_data", {rsp_re, rsp_im}, {rot_re[k % 4], rot_im[k % 4]});
        end
        @(negedge clk);
        mult_res_val = 1'b0;
        req_val = 4'h0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_mult_arbiter.md
# complex_mult_arbiter

Round-robin arbiter that shares the single complex-number multiplier instance between N_REQ independent requesters. It sits between the requesters and the multiplier's op_val/op_ready operand channel and res_val/res_ready result channel. It captures one requester's operands, issues them, and routes the result back to that requester. Exactly one transaction is in flight at a time.

## Interface
- DATA_WIDTH, 8, width of each operand component (two's complement)
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with CNM_ARB_TIMEOUT_EN)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_val  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester operand accept (one-hot or zero)
- req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im  in  N_REQ*DATA_WIDTH each  packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_val  out  N_REQ  per-requester result valid (one-hot or zero)
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_re, rsp_im  out  2*DATA_WIDTH each  result, broadcast to all requesters
- rsp_err  out  1  result is a timeout error, qualified by rsp_val
- mult_op_val  out  1  to multiplier op_val
- mult_op_ready  in  1  from multiplier op_ready
- mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im  out  DATA_WIDTH each  captured operands
- mult_res_val  in  1  from multiplier res_val
- mult_res_ready  out  1  to multiplier res_ready
- mult_result_re, mult_result_im  in  2*DATA_WIDTH each  multiplier result
- mult_sw_rst  out  1  to multiplier sw_rst

## Operation
- States: IDLE, SEND, WAIT, and ABORT/ERR when CNM_ARB_TIMEOUT_EN is defined.
- IDLE:
  - The grant goes to the first requester with req_val high, scanning from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[grant] is asserted combinationally in the same cycle.
  - On the handshake: capture the four operands into registers, store owner=grant and last_grant=grant, then go to SEND.
  - With no req_val, stay in IDLE.
- SEND:
  - mult_op_val=1 and the mult_op_* outputs drive the captured registers.
  - On mult_op_val & mult_op_ready, go to WAIT.
- WAIT:
  - Pass-through: rsp_val[owner]=mult_res_val, mult_res_ready=rsp_ready[owner], rsp_re/rsp_im=mult_result_re/im.
  - On mult_res_val & rsp_ready[owner], go to IDLE.
- In IDLE and SEND, mult_res_val is ignored and mult_res_ready=0.
- rsp_ready of non-owners is ignored. req_ready is 0 outside IDLE.
- Arithmetic is untouched: results pass through at full width, with no truncation or sign handling in the arbiter.

## Timing
- Reset values:
  - state=IDLE, last_grant=N_REQ-1, so requester 0 wins first.
  - All of req_ready, rsp_val, rsp_err, mult_op_val, mult_res_ready, mult_sw_rst are 0.
  - Operand registers and rsp_re/rsp_im are 0.
- Reset mid-transaction aborts to IDLE silently. The arbiter does not assert mult_sw_rst on rst; the multiplier has its own reset.
- Issue latency: a request accepted in cycle t produces mult_op_val=1 in cycle t+1.
- Result latency: zero cycles of added latency, since the result path is combinational from mult_res_val to rsp_val.
- Back-to-back: the next grant is possible in the cycle after result acceptance.
- Minimum cycles per transaction: 3 plus the multiplier latency.
- A requester that deasserts req_val before its handshake loses its turn, with no penalty.
- Simultaneous requests from all requesters are served in strict rotation.

## Configuration
- CNM_ARB_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle in which mult_res_val=0.
  - When the counter reaches TIMEOUT_CYCLES, go to ABORT: mult_sw_rst=1 for exactly one cycle.
  - Then ERR: rsp_val[owner]=1, rsp_err=1, rsp_re=rsp_im=0, held until rsp_ready[owner]; then IDLE.
- CNM_ARB_TIMEOUT_EN undefined:
  - No counter, ABORT, or ERR states.
  - mult_sw_rst and rsp_err are tied 0; TIMEOUT_CYCLES is unused.
  - WAIT waits indefinitely.

## Structure
- Shared package/include file cnm_arb_pkg holds:
  - state encodings (IDLE=0, SEND=1, WAIT=2, ABORT=3, ERR=4)
  - the requester-ID width function clog2(N_REQ)
  - the default TIMEOUT_CYCLES
- One sub-module, rr_priority_picker:
  - inputs: request vector, last_grant
  - outputs: one-hot grant, grant index, any_req
  - purely combinational
- FSM, operand registers and watchdog live in the top module.

## Test plan
- Single request: requester 2 sends (3+4j)×(1−2j) at DATA_WIDTH=8 -> req_ready[2] in the same cycle, mult_op_val next cycle, rsp_val[2] only, rsp_re=11, rsp_im=−2.
- All four requesters hold req_val constantly -> grants in order 0,1,2,3,0,1; each result reaches only its owner.
- Owner stalls rsp_ready for 5 cycles -> mult_res_ready held 0, result stable, no new grant.
- mult_op_ready low 3 cycles in SEND -> mult_op_val and operands stable until accepted.
- rst asserted in WAIT -> next cycle all outputs 0, state IDLE, requester 0 has priority.
- CNM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, multiplier never responds -> mult_sw_rst high exactly one cycle after 8 WAIT cycles, then rsp_val[owner]=1, rsp_err=1, result 0.
